// File: rtl/acs_seq_engine.sv
// acs_seq_engine: time-multiplexed add-compare-select for the K=7, rate-1/2 hard-decision Viterbi decoder.
// Optional ACS_NORM_EN: each step subtracts the previous step's minimum from every metric it reads.
module acs_seq_engine #(
  parameter int unsigned     PM_W    = 8,
  parameter logic [6:0]      G0      = 7'b1111001,
  parameter logic [6:0]      G1      = 7'b1011011,
  parameter logic [PM_W-1:0] INIT_PM = PM_W'(1) << (PM_W - 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      rx_pair,
  input  logic            rx_valid,
  input  logic            frame_start,
  output logic            rx_ready,
  output logic [63:0]     dec_word,
  output logic [5:0]      best_state,
  output logic [PM_W-1:0] min_pm,
  output logic            dec_valid,
  input  logic            dec_ready
);

  localparam int unsigned N_ST  = 64;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                bank_q;
  logic [1:0]          rx_q;
  logic                fs_q;
  logic [PM_W-1:0]     run_min_q;
  logic [5:0]          run_idx_q;
  logic [PM_W-1:0]     off_c;
  logic [PM_W-1:0]     pm_mem [2][N_ST];

  logic [5:0]          idx_e, idx_o, idx_lo, idx_hi;
  logic [PM_W-1:0]     pm_e, pm_o;
  logic [PM_W-1:0]     cand_e0, cand_o0, cand_e1, cand_o1;
  logic [PM_W-1:0]     new_lo, new_hi, pair_val, best_val_c;
  logic [5:0]          pair_idx, best_idx_c;
  logic                dec_lo, dec_hi;

`ifdef ACS_NORM_EN
  logic [PM_W-1:0]     off_q;
  assign off_c = off_q;
`else
  assign off_c = '0;
`endif

  assign rx_ready = (state_q == IDLE);

  function automatic logic [1:0] branch_metric(input logic u, input logic [5:0] s,
                                               input logic [1:0] rx);
    logic [6:0] enc;
    logic       c0, c1;
    enc = {u, s};
    c0  = ^(G0 & enc);
    c1  = ^(G1 & enc);
    return {1'b0, rx[0] ^ c0} + {1'b0, rx[1] ^ c1};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + (PM_W+1)'(b);
    return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  assign idx_e  = {cnt_q, 1'b0};
  assign idx_o  = {cnt_q, 1'b1};
  assign idx_lo = {1'b0, cnt_q};
  assign idx_hi = {1'b1, cnt_q};

  // One butterfly: predecessors 2j/2j+1 feed successors j (u=0) and j+32 (u=1)
  always_comb begin
    pm_e = pm_mem[bank_q][idx_e] - off_c;
    pm_o = pm_mem[bank_q][idx_o] - off_c;
    if (fs_q) begin
      pm_e = (cnt_q == '0) ? '0 : INIT_PM;
      pm_o = INIT_PM;
    end
    cand_e0 = sat_add(pm_e, branch_metric(1'b0, idx_e, rx_q));
    cand_o0 = sat_add(pm_o, branch_metric(1'b0, idx_o, rx_q));
    cand_e1 = sat_add(pm_e, branch_metric(1'b1, idx_e, rx_q));
    cand_o1 = sat_add(pm_o, branch_metric(1'b1, idx_o, rx_q));
    dec_lo  = (cand_o0 < cand_e0);
    dec_hi  = (cand_o1 < cand_e1);
    new_lo  = dec_lo ? cand_o0 : cand_e0;
    new_hi  = dec_hi ? cand_o1 : cand_e1;
    pair_val = new_lo;
    pair_idx = idx_lo;
    if (new_hi < new_lo) begin
      pair_val = new_hi;
      pair_idx = idx_hi;
    end
    // States are visited out of index order, so ties compare indices explicitly
    best_val_c = run_min_q;
    best_idx_c = run_idx_q;
    if ((cnt_q == '0) || (pair_val < run_min_q) ||
        ((pair_val == run_min_q) && (pair_idx < run_idx_q))) begin
      best_val_c = pair_val;
      best_idx_c = pair_idx;
    end
  end

  // Ping-pong metric banks: read bank_q, write the other
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < int'(N_ST); i++)
          pm_mem[b][i] <= (i == 0) ? '0 : INIT_PM;
    end else if (state_q == RUN) begin
      pm_mem[~bank_q][idx_lo] <= new_lo;
      pm_mem[~bank_q][idx_hi] <= new_hi;
    end
  end

  // Step sequencing and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bank_q     <= 1'b0;
      rx_q       <= '0;
      fs_q       <= 1'b0;
      run_min_q  <= '0;
      run_idx_q  <= '0;
      dec_valid  <= 1'b0;
      dec_word   <= '0;
      best_state <= '0;
      min_pm     <= '0;
`ifdef ACS_NORM_EN
      off_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rx_q    <= rx_pair;
            fs_q    <= frame_start;
`ifdef ACS_NORM_EN
            if (frame_start) off_q <= '0;
`endif
          end
        end
        RUN: begin
          dec_word[idx_lo] <= dec_lo;
          dec_word[idx_hi] <= dec_hi;
          run_min_q        <= best_val_c;
          run_idx_q        <= best_idx_c;
          cnt_q            <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q    <= OUT;
            dec_valid  <= 1'b1;
            min_pm     <= best_val_c;
            best_state <= best_idx_c;
            bank_q     <= ~bank_q;
            fs_q       <= 1'b0;
`ifdef ACS_NORM_EN
            off_q      <= best_val_c;
`endif
          end
        end
        OUT: begin
          if (dec_ready) begin
            state_q   <= IDLE;
            dec_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
